// File: rtl/systolic_seq_if.sv
// systolic_seq_if: host <-> systolic sequencer control/status bundle.
// master = host side, slave = sequencer side.
interface systolic_seq_if #(
   parameter int ADDR_W = 7,
   parameter int CYC_W  = 9,
   parameter int IDX_W  = 6,
   parameter int SET_W  = 2
);
   logic              tpu_start;
   logic [IDX_W-1:0]  cfg_last_idx;
   logic [SET_W-1:0]  cfg_last_set;
   logic              stall;
   logic              abort;
   logic              sram_write_enable;
   logic [ADDR_W-1:0] addr_serial_num;
   logic              alu_start;
   logic [CYC_W-1:0]  cycle_num;
   logic [IDX_W-1:0]  matrix_index;
   logic [SET_W-1:0]  data_set;
   logic              busy;
   logic              tpu_done;
   modport master (
      output tpu_start, cfg_last_idx, cfg_last_set, stall, abort,
      input  sram_write_enable, addr_serial_num, alu_start, cycle_num,
             matrix_index, data_set, busy, tpu_done
   );
   modport slave (
      input  tpu_start, cfg_last_idx, cfg_last_set, stall, abort,
      output sram_write_enable, addr_serial_num, alu_start, cycle_num,
             matrix_index, data_set, busy, tpu_done
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: IDLE/LOAD/WAIT/ROLL sequencer driving systolic shift and output write-out.
// Define SYSCTRL_STALL_EN to let stall freeze the ROLL phase; otherwise stall is ignored.
module systolic_seq_ctrl #(
   parameter int ARRAY_SIZE = 16,
   parameter int ADDR_W     = 7,
   parameter int CYC_W      = 9,
   parameter int IDX_W      = 6,
   parameter int SET_W      = 2
) (
   input logic           clk,
   input logic           srstn,
   systolic_seq_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, ROLL = 2'd3;
   localparam logic [CYC_W-1:0] WIN = CYC_W'(ARRAY_SIZE + 1);
   logic [1:0]        state;
   logic [IDX_W-1:0]  last_idx, idx;
   logic [SET_W-1:0]  last_set, set;
   logic [ADDR_W-1:0] addr;
   logic [CYC_W-1:0]  cyc;
   logic              done, stl, run, wr, fin;
`ifdef SYSCTRL_STALL_EN
   assign stl = bus.stall;
`else
   assign stl = 1'b0;
`endif
   assign run = state == ROLL && !stl;
   assign wr  = run && cyc >= WIN;
   assign fin = wr && idx == last_idx && set == last_set;
   assign bus.alu_start         = run;
   assign bus.sram_write_enable = wr;
   assign bus.busy              = state != IDLE;
   assign bus.addr_serial_num   = addr;
   assign bus.cycle_num         = cyc;
   assign bus.matrix_index      = idx;
   assign bus.data_set          = set;
   assign bus.tpu_done          = done;
   always_ff @(posedge clk or negedge srstn)
      if (!srstn) begin
         state    <= IDLE;
         last_idx <= '0;
         last_set <= '0;
         addr     <= '0;
         cyc      <= '0;
         idx      <= '0;
         set      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (bus.tpu_start) begin
               state    <= LOAD;
               last_idx <= bus.cfg_last_idx;
               last_set <= bus.cfg_last_set;
               addr     <= '0;
               cyc      <= '0;
               idx      <= '0;
               set      <= '0;
            end
         end else if (bus.abort) begin
            state <= IDLE;
            addr  <= '0;
            cyc   <= '0;
            idx   <= '0;
            set   <= '0;
         end else if (state == LOAD) begin
            state <= WAIT;
            addr  <= ADDR_W'(1);
         end else if (state == WAIT) begin
            state <= ROLL;
            addr  <= ADDR_W'(2);
            cyc   <= '0;
         end else if (fin) begin
            // final write: counters keep their last values for inspection in IDLE
            state <= IDLE;
            done  <= 1'b1;
         end else if (run) begin
            addr <= addr == '1 ? addr : addr + ADDR_W'(1);
            cyc  <= cyc == '1 ? cyc : cyc + CYC_W'(1);
            if (wr) begin
               idx <= idx == last_idx ? '0 : idx + IDX_W'(1);
               set <= idx == last_idx ? set + SET_W'(1) : set;
            end
         end
      end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed checks of the systolic sequencer (default and 6-bit address builds).
module tb_systolic_seq_ctrl;
`ifdef SYSCTRL_STALL_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif
   logic clk = 1'b0;
   logic srstn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   rolls, wrs, dones, errs, c;
   systolic_seq_if #(.ADDR_W(7)) s ();
   systolic_seq_if #(.ADDR_W(6)) s6 ();
   assign s6.tpu_start    = s.tpu_start;
   assign s6.cfg_last_idx = s.cfg_last_idx;
   assign s6.cfg_last_set = s.cfg_last_set;
   assign s6.stall        = s.stall;
   assign s6.abort        = s.abort;
   systolic_seq_ctrl dut (.clk(clk), .srstn(srstn), .bus(s.slave));
   systolic_seq_ctrl #(.ADDR_W(6)) dut6 (.clk(clk), .srstn(srstn), .bus(s6.slave));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one start-to-IDLE run, tracking a reference model of the counters every ROLL cycle
   task automatic run(input int li, input int ls, input int stall_at, input int abort_at,
                      output int n_roll, output int n_wr, output int n_done, output int n_err);
      int ec, ei, es, ea, sl;
      bit sd, st;
      n_roll = 0; n_wr = 0; n_done = 0; n_err = 0;
      ec = 0; ei = 0; es = 0; sl = 0; sd = 1'b0;
      s.cfg_last_idx = 6'(li);
      s.cfg_last_set = 2'(ls);
      s.tpu_start = 1'b1;
      step();
      s.tpu_start = 1'b0;
      if (s.busy !== 1'b1 || s.addr_serial_num !== 7'd0) n_err++;
      step();
      if (s.addr_serial_num !== 7'd1) n_err++;
      step();
      for (int n = 0; n < 400 && s.busy === 1'b1; n++) begin
         n_roll++;
         if (stall_at >= 0 && !sd && sl == 0 && int'(s.cycle_num) == stall_at) begin
            sl = 5;
            sd = 1'b1;
         end
         s.stall = sl > 0;
         if (sl > 0) sl--;
         s.abort = int'(s.cycle_num) == abort_at;
         #1;
         st = STALL_ON && s.stall;
         ea = 2 + ec > 127 ? 127 : 2 + ec;
         if (s.cycle_num !== 9'(ec) || s.addr_serial_num !== 7'(ea)) n_err++;
         if (s.matrix_index !== 6'(ei) || s.data_set !== 2'(es)) n_err++;
         if (s.alu_start !== !st || s.sram_write_enable !== (!st && ec >= 17)) n_err++;
         if (s.sram_write_enable === 1'b1) n_wr++;
         if (!st) begin
            if (ec >= 17) begin
               if (ei == li) begin ei = 0; es++; end
               else ei++;
            end
            ec++;
         end
         step();
         s.stall = 1'b0;
         s.abort = 1'b0;
         if (s.tpu_done === 1'b1) n_done++;
      end
      chk("run_timeout", s.busy, 0);
      step();
      if (s.tpu_done === 1'b1) n_done++;
   endtask

   initial begin
      s.tpu_start = 1'b0; s.stall = 1'b0; s.abort = 1'b0;
      s.cfg_last_idx = '0; s.cfg_last_set = '0;
      step();
      chk("rst_busy", s.busy, 0);
      chk("rst_addr", s.addr_serial_num, 0);
      chk("rst_cyc", s.cycle_num, 0);
      chk("rst_idx_set", {s.matrix_index, s.data_set}, 0);
      chk("rst_done_we_alu", {s.tpu_done, s.sram_write_enable, s.alu_start}, 0);
      srstn = 1'b1;
      step();
      s.abort = 1'b1;
      step();
      s.abort = 1'b0;
      chk("idle_abort_ignored", s.busy, 0);
      // full run, no stall
      run(31, 1, -1, -1, rolls, wrs, dones, errs);
      chk("r1_rolls", rolls, 81);
      chk("r1_writes", wrs, 64);
      chk("r1_done", dones, 1);
      chk("r1_model", errs, 0);
      chk("r1_addr_hold", s.addr_serial_num, 82);
      chk("r1_addr6_sat", s6.addr_serial_num, 63);
      // stall window at cycle_num 18
      run(3, 2, 18, -1, rolls, wrs, dones, errs);
      chk("r2_rolls", rolls, STALL_ON ? 34 : 29);
      chk("r2_writes", wrs, 12);
      chk("r2_done", dones, 1);
      chk("r2_model", errs, 0);
      // abort at cycle_num 20
      run(31, 1, -1, 20, rolls, wrs, dones, errs);
      chk("r3_rolls", rolls, 21);
      chk("r3_done", dones, 0);
      chk("r3_model", errs, 0);
      chk("r3_busy", s.busy, 0);
      chk("r3_cleared", {s.addr_serial_num, s.cycle_num, s.matrix_index, s.data_set}, 0);
      run(3, 0, -1, -1, rolls, wrs, dones, errs);
      chk("r4_rolls", rolls, 21);
      chk("r4_writes", wrs, 4);
      chk("r4_done", dones, 1);
      chk("r4_model", errs, 0);
      // start together with abort in IDLE starts; abort in LOAD cancels
      s.tpu_start = 1'b1; s.abort = 1'b1;
      step();
      s.tpu_start = 1'b0;
      chk("start_abort_starts", s.busy, 1);
      step();
      s.abort = 1'b0;
      chk("load_abort", {s.busy, s.tpu_done}, 0);
      // mid-run start ignored, then asynchronous reset during ROLL
      s.cfg_last_idx = 6'd31; s.cfg_last_set = 2'd1; s.tpu_start = 1'b1;
      step();
      s.tpu_start = 1'b0;
      repeat (12) step();
      c = int'(s.cycle_num);
      chk("mid_cyc", c, 10);
      s.tpu_start = 1'b1;
      step();
      s.tpu_start = 1'b0;
      chk("mid_start_ignored", s.cycle_num, c + 1);
      #2 srstn = 1'b0;
      #1;
      chk("areset_busy", s.busy, 0);
      chk("areset_outs", {s.addr_serial_num, s.cycle_num, s.matrix_index, s.data_set, s.tpu_done}, 0);
      step();
      chk("areset_no_done", s.tpu_done, 0);
      srstn = 1'b1;
      step();
      run(3, 0, -1, -1, rolls, wrs, dones, errs);
      chk("r5_done", dones, 1);
      chk("r5_model", errs, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 Parameter ARRAY_SIZE, default 16, systolic array edge length; the write window opens at cycle_num >= ARRAY_SIZE+1.
REQ-002 Parameter ADDR_W, default 7, width of addr_serial_num.
REQ-003 Parameter CYC_W, default 9, width of cycle_num.
REQ-004 Parameter IDX_W, default 6, width of matrix_index and cfg_last_idx.
REQ-005 Parameter SET_W, default 2, width of data_set and cfg_last_set.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 srstn  input  1  reset, asynchronous, active-low.
REQ-008 tpu_start  input  1  run request, sampled in IDLE only.
REQ-009 cfg_last_idx  input  IDX_W  last matrix_index of a data set, latched on accepted start.
REQ-010 cfg_last_set  input  SET_W  last data_set of a run, latched on accepted start.
REQ-011 stall  input  1  freeze request from SRAM/downstream side.
REQ-012 abort  input  1  cancel the current run.
REQ-013 sram_write_enable  output  1  write strobe for the output SRAM.
REQ-014 addr_serial_num  output  ADDR_W  input-buffer address sequence number.
REQ-015 alu_start  output  1  systolic shift/multiply enable.
REQ-016 cycle_num  output  CYC_W  rolling cycle count.
REQ-017 matrix_index  output  IDX_W  output-row index for write-out.
REQ-018 data_set  output  SET_W  current data set.
REQ-019 busy  output  1  high whenever state is not IDLE.
REQ-020 tpu_done  output  1  one-cycle registered completion pulse.

Function
REQ-021 States SHALL be IDLE, LOAD, WAIT, ROLL: IDLE->LOAD on tpu_start; LOAD->WAIT; WAIT->ROLL; ROLL->IDLE on completion or abort.
REQ-022 An accepted start SHALL latch cfg_last_idx/cfg_last_set and clear cycle_num, matrix_index, data_set and addr_serial_num; tpu_start outside IDLE SHALL be ignored.
REQ-023 addr_serial_num SHALL be 0 in LOAD, 1 in WAIT, 2 in the first ROLL cycle, then +1 per non-stalled ROLL cycle, saturating at 2^ADDR_W-1; it SHALL hold its value in IDLE.
REQ-024 alu_start SHALL be a combinational decode: 1 in ROLL when not stalled, else 0.
REQ-025 cycle_num SHALL be 0 on ROLL entry and increment per non-stalled ROLL cycle, saturating at 2^CYC_W-1.
REQ-026 sram_write_enable SHALL be combinational, high in ROLL when not stalled and cycle_num >= ARRAY_SIZE+1.
REQ-027 On each write cycle matrix_index SHALL increment; at cfg_last_idx it SHALL wrap to 0 and data_set SHALL increment.
REQ-028 A write cycle with matrix_index==cfg_last_idx and data_set==cfg_last_set SHALL complete the run: next state IDLE, tpu_done=1 for exactly the following cycle.
REQ-029 While stalled, all counters and state SHALL hold and no write or alu_start SHALL occur; stall SHALL have no effect in IDLE, LOAD or WAIT.
REQ-030 abort in LOAD/WAIT/ROLL SHALL force IDLE next cycle and clear counters, with no tpu_done; abort SHALL take priority over stall and completion; abort in IDLE SHALL be ignored.
REQ-031 tpu_start and abort high together in IDLE SHALL start a run.

Reset
REQ-032 srstn low SHALL immediately force IDLE with all registered outputs 0 (addr_serial_num, cycle_num, matrix_index, data_set, tpu_done) and the latched config 0.
REQ-033 Reset asserted mid-run SHALL discard the run with no tpu_done; operation SHALL resume on the first rising clk edge after srstn deasserts.

Configuration
REQ-034 Macro SYSCTRL_STALL_EN defined: stall SHALL behave as in REQ-029.
REQ-035 SYSCTRL_STALL_EN undefined: the stall port SHALL remain present but be ignored, and the block SHALL behave as if stall were always 0.

Verification
REQ-036 Reset, then start with last_idx=31, last_set=1 and no stall -> LOAD, WAIT, 81 ROLL cycles, first 17 without writes, then 64 write pulses, tpu_done high 1 cycle, busy low.
REQ-037 Same run with ADDR_W=7 -> addr_serial_num counts 2..82 over ROLL, then holds 82 in IDLE; with ADDR_W=6, saturates at 63.
REQ-038 last_idx=3, last_set=2, stall high for 5 cycles at cycle_num=18 -> counters frozen for 5 cycles, 12 writes total, index sequence 0..3 repeated x3, tpu_done once.
REQ-039 abort at cycle_num=20 -> IDLE next cycle, counters 0, no tpu_done; a new start then completes normally.
REQ-040 srstn low during ROLL -> immediate IDLE, outputs 0, no tpu_done; tpu_start pulsed mid-run -> no effect.
REQ-041 Build without SYSCTRL_STALL_EN and repeat REQ-038 -> no freeze, run completes 5 cycles earlier.
